// File: rtl/serial_rx_if.sv
// Bus bundle between the 8N1 UART receiver and its consumer.
// The receiver takes the slave side. The line driver and byte consumer take the master side.
interface serial_rx_if;
    logic       rx;
    logic       wr;
    logic [7:0] data;
    logic       err;
    logic       busy;

    modport master (output rx, input wr, data, err, busy);
    modport slave  (input rx, output wr, data, err, busy);
endinterface

// File: rtl/serial_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte strobe, framing-error strobe, break hold-off.
// Optional macro SERIAL_RX_SYNC_EN adds a two-flop input synchroniser for use straight behind a pad.
module serial_rx #(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    serial_rx_if.slave  if_rx
);
    localparam int BIT_TICKS  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = $clog2(BIT_TICKS);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_TICKS - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_wr;
    logic             r_err;
    logic             r_busy;
    logic             w_rx_s;

`ifdef SERIAL_RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], if_rx.rx};
        end
    end

    assign w_rx_s = r_sync[1];
`else
    assign w_rx_s = if_rx.rx;
`endif

    // The tick counter counts down to zero, and the line is sampled on the zero cycle.
    // START loads half a bit, so every sample after it falls at mid-bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_wr    <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_wr  <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= ~w_rx_s;
                    if (!w_rx_s) begin
                        r_cnt   <= HALF_LOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_busy <= 1'b1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= '0;
                        r_cnt   <= BIT_LOAD;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_busy <= 1'b1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        r_cnt   <= BIT_LOAD;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    r_busy <= 1'b1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_rx_s) begin
                        r_wr    <= 1'b1;
                        r_data  <= r_shift;
                        r_state <= S_IDLE;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    // A line held low must not be decoded as a stream of 0x00 frames.
                    r_busy <= 1'b1;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_rx.wr   = r_wr;
    assign if_rx.data = r_data;
    assign if_rx.err  = r_err;
    assign if_rx.busy = r_busy;
endmodule
